spram_be_init: RTL

Parametrised single-port synchronous RAM, the successor to the plain single-port RAM. It adds per-byte write enables, a selectable 1- or 2-cycle read latency with a read-valid strobe, and a hardware initialisation sweep. The sweep fills every word with a constant after reset, or on request, before any access is accepted. It serves as the generic on-chip buffer for datapath blocks that need known memory contents without a software clear pass.

---
 rtl/spram_pkg.sv | 30 +++
 rtl/spram_be_core.sv | 50 +++++
 rtl/spram_be_init.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spram_pkg.sv
// Shared types and elaboration helpers for the byte-enabled single-port RAM.
// Contents:
//   state_e        - controller state (sweep / run)
//   calc_nb        - byte lanes per word
//   calc_aw        - address width from depth
//   rd_latency_ok  - legal read-latency check
package spram_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Number of byte lanes in a word.
    function automatic int unsigned calc_nb(input int unsigned data_width,
                                            input int unsigned byte_width);
        return (byte_width == 0) ? 1 : data_width / byte_width;
    endfunction

    // Address width; at least one bit even for degenerate depths.
    function automatic int unsigned calc_aw(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Only 1- and 2-cycle read latencies are implemented.
    function automatic bit rd_latency_ok(input int unsigned rd_latency);
        return (rd_latency == 1) || (rd_latency == 2);
    endfunction

endpackage

// File: rtl/spram_be_core.sv
// Byte-enabled single-port storage array with a registered read port.
// No reset: contents and read register are defined by the sweep and reads.
// Ports:
//   clk_i   - clock
//   we_i    - write strobe
//   be_i    - active-high byte write enables (NB)
//   addr_i  - word address (AW)
//   wdata_i - write data
//   re_i    - read strobe; loads rdata_o from mem[addr_i]
//   rdata_o - registered read data, holds between reads
module spram_be_core
    import spram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned DEPTH      = 1024,
    parameter              RAM_STYLE_VAL = "block",
    localparam int unsigned NB = calc_nb(DATA_WIDTH, BYTE_WIDTH),
    localparam int unsigned AW = calc_aw(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [NB-1:0]         be_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    (* ram_style = RAM_STYLE_VAL *)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Per-lane write plus registered read on the shared address.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spram_be_init.sv
// Single-port synchronous RAM with byte write enables, 1- or 2-cycle read
// latency with a read-valid strobe, and a hardware fill sweep after reset or
// on INIT request.
// Ports:
//   CLK   - clock
//   RSTN  - async active-low reset
//   CEN   - chip enable, active low
//   WEN   - 0 write / 1 read
//   BEN   - byte write enables, active low (NB)
//   A     - word address (AW)
//   D     - write data
//   INIT  - re-initialisation request, active high
//   Q     - read data, holds between reads
//   QV    - one-cycle strobe for new data on Q
//   READY - sweep done, accesses accepted
module spram_be_init
    import spram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           BYTE_WIDTH    = 8,
    parameter int unsigned           DEPTH         = 1024,
    parameter int unsigned           RD_LATENCY    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL      = '0,
    parameter                        RAM_STYLE_VAL = "block",
    localparam int unsigned NB = calc_nb(DATA_WIDTH, BYTE_WIDTH),
    localparam int unsigned AW = calc_aw(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CEN,
    input  logic                  WEN,
    input  logic [NB-1:0]         BEN,
    input  logic [AW-1:0]         A,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  INIT,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  QV,
    output logic                  READY
);

    // Elaboration-time parameter legality.
    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("spram_be_init: RD_LATENCY must be 1 or 2");
    end
    if ((BYTE_WIDTH == 0) || ((DATA_WIDTH % BYTE_WIDTH) != 0)) begin : g_bad_width
        $error("spram_be_init: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("spram_be_init: DEPTH must be at least 2");
    end

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            ready_q;
    logic            qv1_q;
    logic            oor_q;

    logic            in_range_c;
    logic            acc_c;
    logic            rd_acc_c;
    logic            wr_acc_c;

    logic                  mem_we;
    logic [NB-1:0]         mem_be;
    logic [AW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] stage1_c;

    // READY is high exactly in S_RUN; INIT steals the edge from any access.
    assign in_range_c = (32'(A) < DEPTH);
    assign acc_c      = ready_q & ~CEN & ~INIT;
    assign rd_acc_c   = acc_c & WEN;
    assign wr_acc_c   = acc_c & ~WEN & in_range_c;

    // Write-port mux: sweep owns the array while in S_INIT.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = A;
        mem_wdata = D;
        mem_re    = 1'b0;
        if (state_q == S_INIT) begin
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = cnt_q;
            mem_wdata = INIT_VAL;
        end else begin
            mem_we = wr_acc_c;
            mem_be = ~BEN;
            mem_re = rd_acc_c & in_range_c;
        end
    end

    spram_be_core #(
        .DATA_WIDTH    (DATA_WIDTH),
        .BYTE_WIDTH    (BYTE_WIDTH),
        .DEPTH         (DEPTH),
        .RAM_STYLE_VAL (RAM_STYLE_VAL)
    ) u_core (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .re_i    (mem_re),
        .rdata_o (mem_rdata)
    );

    // Controller FSM, sweep counter and first read-valid stage.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            qv1_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            qv1_q <= rd_acc_c;
            if (rd_acc_c) begin
                oor_q <= ~in_range_c;
            end
            case (state_q)
                S_INIT: begin
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                S_RUN: begin
                    if (INIT) begin
                        state_q <= S_INIT;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range reads never touch the array; they return the fill word.
    assign stage1_c = oor_q ? INIT_VAL : mem_rdata;

    if (RD_LATENCY == 1) begin : g_lat1
        logic have_q;

        // Masks the unreset array register until the first read after reset.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                have_q <= 1'b0;
            end else if (rd_acc_c) begin
                have_q <= 1'b1;
            end
        end

        assign Q  = have_q ? stage1_c : '0;
        assign QV = qv1_q;
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] q2_q;
        logic                  qv2_q;

        // Second output register, loaded only when stage one has new data.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                q2_q  <= '0;
                qv2_q <= 1'b0;
            end else begin
                qv2_q <= qv1_q;
                if (qv1_q) begin
                    q2_q <= stage1_c;
                end
            end
        end

        assign Q  = q2_q;
        assign QV = qv2_q;
    end

    assign READY = ready_q;

endmodule
